// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_set_ctrl
// Brief   : Key debounce plus RUN / SET_TIME / SET_ALARM edit controller.
// Revision: 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
   parameter int DEB_CYCLES = 20,
   parameter int DEB_W      = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode_n,
   input  logic       key_sel_n,
   input  logic       key_inc_n,
   input  logic       key_alm_n,
   input  logic [3:0] cur_sec_ge,
   input  logic [3:0] cur_sec_shi,
   input  logic [3:0] cur_min_ge,
   input  logic [3:0] cur_min_shi,
   input  logic [3:0] cur_hour_ge,
   input  logic [3:0] cur_hour_shi,
   output logic       set_time_finish,
   output logic [3:0] set_sec_ge,
   output logic [3:0] set_sec_shi,
   output logic [3:0] set_min_ge,
   output logic [3:0] set_min_shi,
   output logic [3:0] set_hour_ge,
   output logic [3:0] set_hour_shi,
   output logic       clock_en,
   output logic [3:0] clock_min_ge,
   output logic [3:0] clock_min_shi,
   output logic [3:0] clock_hour_ge,
   output logic [3:0] clock_hour_shi,
   output logic [1:0] mode,
   output logic [2:0] cursor
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_SET_TIME  = 2'd1,
      ST_SET_ALARM = 2'd2
   } state_t;

   localparam logic [DEB_W-1:0] C_DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [3:0] w_raw;
   logic [3:0] w_press;
   assign w_raw = {key_alm_n, key_inc_n, key_sel_n, key_mode_n};

   for (genvar k = 0; k < 4; k++) begin : g_deb
      logic [1:0]       r_sync;
      logic             r_stable;
      logic             r_press;
      logic [DEB_W-1:0] r_cnt;
      logic             w_flip;

      assign w_flip     = (r_sync[1] != r_stable) && (r_cnt == C_DEB_LAST);
      assign w_press[k] = r_press;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
         end else begin
            r_sync  <= {r_sync[0], w_raw[k]};
            r_press <= w_flip & r_stable;
            if (r_sync[1] == r_stable) begin
               r_cnt <= '0;
            end else if (w_flip) begin
               r_stable <= ~r_stable;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // Only the highest-priority pulse of a cycle is acted on.
   logic w_mode, w_sel, w_inc, w_alm;
   assign w_mode = w_press[0];
   assign w_sel  = w_press[1] & ~w_press[0];
   assign w_inc  = w_press[2] & ~w_press[1] & ~w_press[0];
   assign w_alm  = w_press[3] & ~w_press[2] & ~w_press[1] & ~w_press[0];

   function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] mx);
      return (d >= mx) ? 4'd0 : d + 4'd1;
   endfunction

   // Returns {hour_shi, hour_ge}; tens-of-hours reaching 2 clamps units to 3.
   function automatic logic [7:0] hour_inc(input logic [3:0] hs, input logic [3:0] hg,
                                           input logic on_shi);
      logic [3:0] ns;
      logic [3:0] ng;
      ns = hs;
      ng = hg;
      if (on_shi) begin
         ns = wrap_inc(hs, 4'd2);
         if (ns == 4'd2 && hg > 4'd3) ng = 4'd3;
      end else begin
         ng = wrap_inc(hg, (hs == 4'd2) ? 4'd3 : 4'd9);
      end
      return {ns, ng};
   endfunction

   state_t          r_state, w_state_nx;
   logic [2:0]      r_cursor, w_cursor_nx;
   logic [5:0][3:0] r_set, w_set_nx;
   logic [3:0][3:0] r_alm, w_alm_nx;
   logic            r_en, w_en_nx;
   logic            r_stf, w_stf_nx;
   logic [5:0][3:0] w_cur;

   assign w_cur = {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_RUN;
         r_cursor <= 3'd0;
         r_set    <= '0;
         r_alm    <= {4'd0, 4'd7, 4'd0, 4'd0};
         r_en     <= 1'b0;
         r_stf    <= 1'b1;
      end else begin
         r_state  <= w_state_nx;
         r_cursor <= w_cursor_nx;
         r_set    <= w_set_nx;
         r_alm    <= w_alm_nx;
         r_en     <= w_en_nx;
         r_stf    <= w_stf_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_cursor_nx = r_cursor;
      w_set_nx    = r_set;
      w_alm_nx    = r_alm;
      w_en_nx     = r_en;
      w_stf_nx    = r_stf;
      if (w_mode) begin
         w_cursor_nx = 3'd0;
         case (r_state)
            ST_RUN: begin
               w_state_nx = ST_SET_TIME;
               w_set_nx   = w_cur;
               w_stf_nx   = 1'b0;
            end
            ST_SET_TIME: begin
               w_state_nx = ST_SET_ALARM;
               w_stf_nx   = 1'b1;
            end
            default: begin
               w_state_nx = ST_RUN;
               w_stf_nx   = 1'b1;
            end
         endcase
      end else if (w_sel) begin
         if (r_state == ST_SET_TIME)
            w_cursor_nx = (r_cursor >= 3'd5) ? 3'd0 : r_cursor + 3'd1;
         else if (r_state == ST_SET_ALARM)
            w_cursor_nx = (r_cursor >= 3'd3) ? 3'd0 : r_cursor + 3'd1;
      end else if (w_inc) begin
         if (r_state == ST_SET_TIME) begin
            if (r_cursor >= 3'd4)
               {w_set_nx[5], w_set_nx[4]} = hour_inc(r_set[5], r_set[4], r_cursor == 3'd5);
            else
               w_set_nx[{1'b0, r_cursor[1:0]}] =
                  wrap_inc(r_set[{1'b0, r_cursor[1:0]}], r_cursor[0] ? 4'd5 : 4'd9);
         end else if (r_state == ST_SET_ALARM) begin
            if (r_cursor[1])
               {w_alm_nx[3], w_alm_nx[2]} = hour_inc(r_alm[3], r_alm[2], r_cursor[0]);
            else
               w_alm_nx[r_cursor[1:0]] =
                  wrap_inc(r_alm[r_cursor[1:0]], r_cursor[0] ? 4'd5 : 4'd9);
         end
      end else if (w_alm) begin
         w_en_nx = ~r_en;
      end
   end

   assign mode            = r_state;
   assign cursor          = r_cursor;
   assign set_time_finish = r_stf;
   assign {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge} = r_set;
   assign clock_en        = r_en;
   assign {clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge} = r_alm;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_set_ctrl
// Brief   : Directed plus randomized key stimulus against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;
   localparam int DEB = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_mode_n = 1'b1, key_sel_n = 1'b1, key_inc_n = 1'b1, key_alm_n = 1'b1;
   logic [3:0] cur_sec_ge = 0, cur_sec_shi = 0, cur_min_ge = 0, cur_min_shi = 0;
   logic [3:0] cur_hour_ge = 0, cur_hour_shi = 0;
   logic       set_time_finish, clock_en;
   logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
   logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;
   logic [1:0] mode;
   logic [2:0] cursor;

   clock_set_ctrl #(.DEB_CYCLES(DEB), .DEB_W(20)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_mode_n(key_mode_n), .key_sel_n(key_sel_n), .key_inc_n(key_inc_n), .key_alm_n(key_alm_n),
      .cur_sec_ge(cur_sec_ge), .cur_sec_shi(cur_sec_shi), .cur_min_ge(cur_min_ge),
      .cur_min_shi(cur_min_shi), .cur_hour_ge(cur_hour_ge), .cur_hour_shi(cur_hour_shi),
      .set_time_finish(set_time_finish),
      .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi), .set_min_ge(set_min_ge),
      .set_min_shi(set_min_shi), .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
      .clock_en(clock_en),
      .clock_min_ge(clock_min_ge), .clock_min_shi(clock_min_shi),
      .clock_hour_ge(clock_hour_ge), .clock_hour_shi(clock_hour_shi),
      .mode(mode), .cursor(cursor)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_press = -1000;
   bit chk_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Model: time digits [0..5] = sec_ge..hour_shi, alarm [0..3] = min_ge..hour_shi.
   int m_mode, m_cursor, m_en;
   int m_set[6];
   int m_alm[4];

   function automatic int bump(input int d, input int mx);
      return (d >= mx) ? 0 : d + 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cursor = 0; m_en = 0;
      foreach (m_set[i]) m_set[i] = 0;
      m_alm[0] = 0; m_alm[1] = 0; m_alm[2] = 7; m_alm[3] = 0;
   endtask

   task automatic model_press(input int k);
      int hs, hg, c;
      c = m_cursor;
      case (k)
         0: begin
            if (m_mode == 0) begin
               m_mode = 1;
               m_set[0] = int'(cur_sec_ge);  m_set[1] = int'(cur_sec_shi);
               m_set[2] = int'(cur_min_ge);  m_set[3] = int'(cur_min_shi);
               m_set[4] = int'(cur_hour_ge); m_set[5] = int'(cur_hour_shi);
            end else if (m_mode == 1) m_mode = 2;
            else m_mode = 0;
            m_cursor = 0;
         end
         1: begin
            if (m_mode == 1) m_cursor = (m_cursor + 1) % 6;
            else if (m_mode == 2) m_cursor = (m_cursor + 1) % 4;
         end
         2: begin
            if (m_mode != 0) begin
               // Hours treated uniformly for time (idx 4,5) and alarm (idx 2,3).
               if (m_mode == 1) begin hs = m_set[5]; hg = m_set[4]; end
               else begin hs = m_alm[3]; hg = m_alm[2]; end
               if ((m_mode == 1 && c == 5) || (m_mode == 2 && c == 3)) begin
                  hs = bump(hs, 2);
                  if (hs == 2 && hg > 3) hg = 3;
               end else if ((m_mode == 1 && c == 4) || (m_mode == 2 && c == 2)) begin
                  hg = bump(hg, (hs == 2) ? 3 : 9);
               end else if (m_mode == 1) begin
                  m_set[c] = bump(m_set[c], (c % 2 == 1) ? 5 : 9);
               end else begin
                  m_alm[c] = bump(m_alm[c], (c % 2 == 1) ? 5 : 9);
               end
               if (m_mode == 1) begin m_set[5] = hs; m_set[4] = hg; end
               else begin m_alm[3] = hs; m_alm[2] = hg; end
            end
         end
         default: m_en = 1 - m_en;
      endcase
   endtask

   function automatic logic [46:0] exp_vec();
      return {2'(m_mode), 3'(m_cursor), (m_mode != 1),
              4'(m_set[5]), 4'(m_set[4]), 4'(m_set[3]), 4'(m_set[2]), 4'(m_set[1]), 4'(m_set[0]),
              1'(m_en), 4'(m_alm[3]), 4'(m_alm[2]), 4'(m_alm[1]), 4'(m_alm[0])};
   endfunction

   logic [46:0] act_vec;
   assign act_vec = {mode, cursor, set_time_finish,
                     set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge,
                     clock_en, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge};

   // Outputs are compared every cycle except inside the debounce latency window.
   always @(negedge clk) begin
      if (chk_on && rst_n && (cyc - last_press > 26)) begin
         total++;
         if (act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL cycle_cmp cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
         end
      end
   end

   task automatic check(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0: key_mode_n = v;
         1: key_sel_n = v;
         2: key_inc_n = v;
         default: key_alm_n = v;
      endcase
   endtask

   task automatic press(input int k, input int hold);
      step(1);
      set_key(k, 1'b0);
      last_press = cyc;
      model_press(k);
      step(hold);
      set_key(k, 1'b1);
      step(30);
   endtask

   task automatic glitch(input int k, input int len);
      step(1);
      set_key(k, 1'b0);
      step(len);
      set_key(k, 1'b1);
      step(25);
   endtask

   task automatic set_cur(input int hs, input int hg, input int ms, input int mg,
                          input int ss, input int sg);
      cur_hour_shi = 4'(hs); cur_hour_ge = 4'(hg);
      cur_min_shi  = 4'(ms); cur_min_ge  = 4'(mg);
      cur_sec_shi  = 4'(ss); cur_sec_ge  = 4'(sg);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n, r, hs;
      model_reset();
      step(3);
      rst_n = 1'b1;
      chk_on = 1'b1;
      step(100);
      check("rst_mode", int'(mode), 0);
      check("rst_cursor", int'(cursor), 0);
      check("rst_stf", int'(set_time_finish), 1);
      check("rst_set_sum", int'(set_sec_ge) + int'(set_sec_shi) + int'(set_min_ge) +
            int'(set_min_shi) + int'(set_hour_ge) + int'(set_hour_shi), 0);
      check("rst_alm_hour_ge", int'(clock_hour_ge), 7);
      check("rst_clock_en", int'(clock_en), 0);

      glitch(3, 5);
      check("alm_glitch", int'(clock_en), 0);

      step(1);
      key_alm_n = 1'b0;
      last_press = cyc;
      model_press(3);
      n = 0;
      while (clock_en == 1'b0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n < 21 || n > 24) begin
         bad++;
         $display("FAIL alm_latency got=%0d want=21..24", n);
      end
      step(30 - ((n < 30) ? n : 29));
      key_alm_n = 1'b1;
      step(30);
      check("alm_once_held", int'(clock_en), 1);
      press(3, 28);
      check("alm_second", int'(clock_en), 0);

      set_cur(1, 3, 4, 5, 2, 7);
      step(3);
      press(0, 30);
      check("enter_mode", int'(mode), 1);
      check("enter_stf", int'(set_time_finish), 0);
      check("enter_digits", {int'(set_hour_shi), int'(set_hour_ge), int'(set_min_shi),
            int'(set_min_ge), int'(set_sec_shi), int'(set_sec_ge)} == {1, 3, 4, 5, 2, 7}, 1);
      for (int i = 1; i <= 6; i++) begin
         press(1, 28);
         check("cursor_seq", int'(cursor), i % 6);
      end

      for (int i = 0; i < 4; i++) press(1, 27);
      for (int i = 0; i < 6; i++) press(2, 27);
      check("hour19_ge", int'(set_hour_ge), 9);
      press(1, 27);
      press(2, 27);
      check("hs2_shi", int'(set_hour_shi), 2);
      check("hs2_ge_clamp", int'(set_hour_ge), 3);
      press(2, 27);
      check("hs0_shi", int'(set_hour_shi), 0);
      check("hs0_ge", int'(set_hour_ge), 3);
      press(2, 27);
      press(2, 27);
      for (int i = 0; i < 5; i++) press(1, 27);
      check("cursor4", int'(cursor), 4);
      press(2, 27);
      check("hg_wrap23", int'(set_hour_ge), 0);

      press(0, 27);
      check("alarm_mode", int'(mode), 2);
      check("alarm_stf", int'(set_time_finish), 1);
      press(1, 27);
      for (int i = 1; i <= 6; i++) begin
         press(2, 27);
         check("alm_min_shi_seq", int'(clock_min_shi), i % 6);
      end
      press(2, 27);
      step(1);
      key_mode_n = 1'b0;
      key_inc_n = 1'b0;
      last_press = cyc;
      model_press(0);
      step(30);
      key_mode_n = 1'b1;
      key_inc_n = 1'b1;
      step(30);
      check("prio_mode", int'(mode), 0);
      check("prio_alm_digit", int'(clock_min_shi), 1);

      press(0, 27);
      press(2, 27);
      check("edit_sec_ge", int'(set_sec_ge), 8);
      @(posedge clk); #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_mode", int'(mode), 0);
      check("arst_stf", int'(set_time_finish), 1);
      check("arst_sec_ge", int'(set_sec_ge), 0);
      @(posedge clk); #1;
      check("arst_next_mode", int'(mode), 0);
      check("arst_next_set", int'(set_sec_ge) + int'(set_hour_ge) + int'(set_min_shi), 0);
      check("arst_next_alm", int'(clock_hour_ge), 7);
      step(2);
      rst_n = 1'b1;
      step(5);

      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 1) begin
            if ($urandom_range(0, 3) == 0) begin
               set_cur($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            end else begin
               hs = $urandom_range(0, 2);
               set_cur(hs, $urandom_range(0, (hs == 2) ? 3 : 9), $urandom_range(0, 5),
                       $urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9));
            end
            step(2);
         end else if (r == 2) begin
            glitch($urandom_range(0, 3), $urandom_range(1, 15));
         end else if (r == 3) begin
            press(0, $urandom_range(26, 40));
         end else if (r <= 5) begin
            press(1, $urandom_range(26, 40));
         end else if (r <= 8) begin
            press(2, $urandom_range(26, 40));
         end else begin
            press(3, $urandom_range(26, 40));
         end
      end
      step(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
